// File: rtl/fetch_unit.sv
// Instruction fetch unit: a PC register drives instruction memory, and each
// fetched word is captured together with its address and a misalignment tag
// into a small FIFO that feeds decode.
//
// Handshake: o_valid/i_ready follow strict valid/ready semantics. An entry
// transfers on a rising edge where o_valid && i_ready. While o_valid=1 and
// i_ready=0 the head outputs hold steady. A redirect overrides everything in
// its cycle: the buffer is flushed even if a transfer would have happened, and
// the head offered in that cycle still counts as taken by decode.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module fetch_unit #(
  parameter logic [`XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int               DEPTH    = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  output logic [`XLEN-1:0]       o_imem_addr,
  input  logic [`INST_WIDTH-1:0] i_imem_inst,
  input  logic                   i_redirect,
  input  logic [`XLEN-1:0]       i_redirect_pc,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [`INST_WIDTH-1:0] o_inst,
  output logic [`XLEN-1:0]       o_pc,
  output logic                   o_misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [`XLEN-1:0]       pc;
    logic [`INST_WIDTH-1:0] inst;
    logic                   misaligned;
  } entry_t;

  logic [`XLEN-1:0] pc;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  entry_t           buf_mem [DEPTH];

  logic pop;
  logic push;
  entry_t head;

  // Memory address is the PC itself; there is no other path to memory.
  assign o_imem_addr = pc;

  // Transfer and fetch decisions; a full buffer only accepts a new word when
  // the head leaves in the same cycle, and a redirect suppresses fetching.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    if (count != '0 && i_ready) pop = 1'b1;
    if (!i_redirect && (count < FULL || pop)) push = 1'b1;
  end

  // Head outputs come straight from buffer registers, never from memory.
  assign head         = buf_mem[rd_ptr];
  assign o_valid      = (count != '0);
  assign o_inst       = head.inst;
  assign o_pc         = head.pc;
  assign o_misaligned = head.misaligned;

  // PC, pointers, occupancy and buffer storage; reset clears all of it at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
    end else if (i_redirect) begin
      pc     <= i_redirect_pc;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= '{pc: pc, inst: i_imem_inst, misaligned: (pc[1:0] != 2'b00)};
        wr_ptr          <= wr_ptr + AW'(1);
        pc              <= pc + `XLEN'(4);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, fetch buffer entries (power of two, >=2).
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 o_imem_addr  output  `XLEN  byte address to instruction memory; equals PC register.
REQ-006 i_imem_inst  input  `INST_WIDTH  instruction returned combinationally for o_imem_addr, same cycle.
REQ-007 i_redirect  input  1  flush and restart fetch (branch/jump/trap).
REQ-008 i_redirect_pc  input  `XLEN  restart target, sampled when i_redirect=1.
REQ-009 o_valid  output  1  head buffer entry available to decode.
REQ-010 i_ready  input  1  decode accepts head entry this cycle.
REQ-011 o_inst  output  `INST_WIDTH  head entry instruction.
REQ-012 o_pc  output  `XLEN  head entry fetch address.
REQ-013 o_misaligned  output  1  head entry address had addr[1:0] != 0.

Function
REQ-014 The block SHALL hold a PC register, a DEPTH-entry FIFO of {pc, inst, misaligned}, and read/write pointers plus a count of $clog2(DEPTH)+1 bits.
REQ-015 o_imem_addr SHALL equal PC combinationally; no other path to memory.
REQ-016 Pop SHALL occur when o_valid && i_ready; o_valid SHALL equal (count != 0); o_inst/o_pc/o_misaligned SHALL come from the head entry, registered, no combinational path from i_imem_inst.
REQ-017 Push SHALL occur when !i_redirect && (count < DEPTH || pop); push writes {PC, i_imem_inst, PC[1:0]!=0} and sets PC <= PC + 4.
REQ-018 When count == DEPTH and no pop, no push SHALL occur and PC SHALL hold (stall).
REQ-019 Simultaneous push and pop SHALL leave count unchanged; full-and-pop SHALL still push.
REQ-020 PC + 4 SHALL wrap modulo 2^`XLEN (32'hFFFF_FFFC -> 32'h0000_0000), no error flag.
REQ-021 On i_redirect=1: count and pointers SHALL clear, PC <= i_redirect_pc, no push that cycle; o_valid SHALL be 0 the following cycle.
REQ-022 Redirect SHALL take priority over push and pop in the same cycle; a head entry presented with i_ready=1 in a redirect cycle is still considered consumed by decode, and the buffer is flushed regardless.
REQ-023 Misaligned target SHALL be fetched as-is (o_imem_addr = target) and tagged o_misaligned=1; PC continues +4 from that address; the block raises no other exception.
REQ-024 Latency: instruction at PC becomes visible on o_inst one cycle after o_imem_addr presents PC; steady-state throughput one instruction per cycle with i_ready held 1.
REQ-025 Head outputs SHALL be stable while o_valid=1 and i_ready=0 (no redirect).

Reset
REQ-026 While i_rst_n=0: PC = RESET_PC, count = 0, pointers = 0, o_valid = 0; o_inst, o_pc, o_misaligned = 0.
REQ-027 Reset assertion mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-028 First push SHALL occur on the first rising edge with i_rst_n=1; o_valid=1 after that edge with o_pc = RESET_PC.

Verification
REQ-029 Reset release, i_ready=1, memory word i at address 4i -> o_pc sequence 0,4,8,12 on consecutive cycles, o_inst matches, o_valid stays 1 from cycle 1.
REQ-030 i_ready=0 for 5 cycles after reset -> count reaches 2 (o_pc=0 held), o_imem_addr stalls at 8; i_ready=1 -> o_pc 0,4,8 back-to-back.
REQ-031 Redirect to 32'h0000_0100 while buffer full -> next cycle o_valid=0, o_imem_addr=0x100; following cycle o_pc=0x100.
REQ-032 Redirect to 32'h0000_0102 -> o_pc=0x102, o_misaligned=1; next entry o_pc=0x106, o_misaligned=1.
REQ-033 Redirect to 32'hFFFF_FFFC, i_ready=1 -> o_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-034 Assert i_rst_n=0 between clock edges with 2 entries buffered -> o_valid=0 and o_imem_addr=RESET_PC before next rising edge.
